// File: rtl/str_bus_word_packer_if.sv
// rtl/str_bus_word_packer_if.sv - simple_bus byte-stream interface
//
// Purpose: one-byte valid/ready stream used between bus stages.
// Signals:
//   data  [7:0]  byte payload, driven by the master
//   valid        payload valid, driven by the master
//   ready        slave can accept, driven by the slave
// Modports: master (drives data/valid), slave (drives ready).

interface simple_bus;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/str_bus_word_packer.sv
// rtl/str_bus_word_packer.sv - packs a simple_bus byte stream into little-endian words
//
// Purpose: collects PACK_BYTES consecutive bytes into one word (byte k in
// bits [8k+7:8k]) and presents it on a registered valid/ready output. A
// flush pulse emits the pending partial word with a lane-keep mask.
// Optional feature macro: STR_PACK_STATS_EN adds word_cnt/partial_cnt.
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   bus_in       simple_bus.slave byte input (reads data/valid, drives ready)
//   flush        single-cycle request to emit the pending partial word
//   out_data     packed word, unused lanes are 0
//   out_keep     lane-valid mask for out_data
//   out_valid    output word valid
//   out_ready    downstream accepts the word
//   busy         bytes held, word pending, or flush waiting
//   word_cnt     (STR_PACK_STATS_EN) transferred words, wraps
//   partial_cnt  (STR_PACK_STATS_EN) transferred partial words, wraps

module str_bus_word_packer #(
    parameter int  PACK_BYTES = 4,
    localparam int CNT_W      = $clog2(PACK_BYTES)
) (
    input  logic                    clk,
    input  logic                    rst,
    simple_bus.slave                bus_in,
    input  logic                    flush,
    output logic [8*PACK_BYTES-1:0] out_data,
    output logic [PACK_BYTES-1:0]   out_keep,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy
`ifdef STR_PACK_STATS_EN
    ,
    output logic [15:0]             word_cnt,
    output logic [15:0]             partial_cnt
`endif
);

    localparam int W = 8 * PACK_BYTES;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PACK_BYTES - 1);

    typedef enum logic {FILL, FLUSH_WAIT} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     acc;

    logic             accept;
    logic             out_free;
    logic [CNT_W:0]   n_bytes;
    logic [W-1:0]     acc_next;

    function automatic logic [PACK_BYTES-1:0] keep_mask(input logic [CNT_W:0] n);
        logic [PACK_BYTES-1:0] m;
        m = '0;
        for (int i = 0; i < PACK_BYTES; i++) begin
            if (i < int'(n)) m[i] = 1'b1;
        end
        return m;
    endfunction

    // The only blocking case is a word about to complete while the output
    // register is still occupied and not draining this cycle.
    always_comb begin
        bus_in.ready = !rst && (state == FILL) &&
                       ((cnt != LAST) || !out_valid || out_ready);
    end

    always_comb begin
        accept   = bus_in.valid && bus_in.ready;
        out_free = !out_valid || out_ready;
        // Byte count including any byte landing this very cycle.
        n_bytes  = {1'b0, cnt} + {{CNT_W{1'b0}}, accept};
        acc_next = acc;
        for (int i = 0; i < PACK_BYTES; i++) begin
            if (accept && (cnt == CNT_W'(i))) acc_next[8*i +: 8] = bus_in.data;
        end
    end

    assign busy = (cnt != '0) || out_valid || (state == FLUSH_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            cnt       <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_keep  <= '0;
            out_valid <= 1'b0;
        end else begin
            // Drain first; a load below overrides it for back-to-back words.
            if (out_valid && out_ready) out_valid <= 1'b0;

            case (state)
                FILL: begin
                    if (accept && (cnt == LAST)) begin
                        // Completing byte also consumes any same-cycle flush.
                        out_valid <= 1'b1;
                        out_data  <= acc_next;
                        out_keep  <= '1;
                        cnt       <= '0;
                        acc       <= '0;
                    end else if (flush && (n_bytes != '0)) begin
                        if (out_free) begin
                            out_valid <= 1'b1;
                            out_data  <= acc_next;
                            out_keep  <= keep_mask(n_bytes);
                            cnt       <= '0;
                            acc       <= '0;
                        end else begin
                            state <= FLUSH_WAIT;
                            acc   <= acc_next;
                            cnt   <= n_bytes[CNT_W-1:0];
                        end
                    end else if (accept) begin
                        acc <= acc_next;
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                FLUSH_WAIT: begin
                    // Input is stalled here, so acc/cnt are stable; extra
                    // flush pulses have nothing new to add and are ignored.
                    if (out_free) begin
                        out_valid <= 1'b1;
                        out_data  <= acc;
                        out_keep  <= keep_mask({1'b0, cnt});
                        cnt       <= '0;
                        acc       <= '0;
                        state     <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

`ifdef STR_PACK_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt    <= '0;
            partial_cnt <= '0;
        end else if (out_valid && out_ready) begin
            word_cnt <= word_cnt + 16'd1;
            if (out_keep != '1) partial_cnt <= partial_cnt + 16'd1;
        end
    end
`endif

endmodule
